// File: rtl/hist_pkg.sv
// Shared types for the histogram engine: controller state encoding and the
// pixel-to-bin mapping.
package hist_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CLEAR    = 3'd1,
        RD_IN    = 3'd2,
        WAIT_IN  = 3'd3,
        RD_BIN   = 3'd4,
        WAIT_BIN = 3'd5,
        WR_BIN   = 3'd6,
        FINISH   = 3'd7
    } state_e;

    // Keeps the top BIN_ADDR_W bits of a pixel; caller truncates to the bin width.
    function automatic logic [31:0] bin_of(input logic [31:0] pixel, input int unsigned shift);
        return pixel >> shift;
    endfunction

endpackage

// File: rtl/hist_lat_timer.sv
// Loadable down-counter used to time memory read latencies; expired is high
// while the count is zero.
module hist_lat_timer #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/histogram_engine_ctrl.sv
// Histogram controller: optional bin clear, then one saturating
// read-modify-write per packed input pixel into the scratch memory.
module histogram_engine_ctrl
    import hist_pkg::*;
#(
    parameter int unsigned PIX_W        = 8,
    parameter int unsigned PIX_PER_WORD = 4,
    parameter int unsigned IN_ADDR_W    = 12,
    parameter int unsigned BIN_ADDR_W   = 8,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned IN_RD_LAT    = 3,
    parameter int unsigned SCR_RD_LAT   = 3
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          abort,
    input  logic                          cfg_clear,
    input  logic [IN_ADDR_W:0]            cfg_num_words,
    output logic                          in_mem_re,
    output logic [IN_ADDR_W-1:0]          in_mem_addr,
    input  logic [PIX_PER_WORD*PIX_W-1:0] in_mem_rdata,
    output logic                          scr_re,
    output logic                          scr_we,
    output logic [BIN_ADDR_W-1:0]         scr_addr,
    output logic [CNT_W-1:0]              scr_wdata,
    input  logic [CNT_W-1:0]              scr_rdata,
    output logic                          busy,
    output logic                          done,
    output logic                          sat_flag
);

    localparam int unsigned WORD_W    = PIX_PER_WORD * PIX_W;
    localparam int unsigned LANE_W    = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
    localparam int unsigned MAX_LAT   = (IN_RD_LAT > SCR_RD_LAT) ? IN_RD_LAT : SCR_RD_LAT;
    localparam int unsigned TMR_W     = $clog2(MAX_LAT + 1);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PIX_PER_WORD - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    state_e                state_q, state_d;
    logic                  clear_q, clear_d;
    logic [IN_ADDR_W:0]    num_words_q, num_words_d;
    logic [IN_ADDR_W:0]    word_idx_q, word_idx_d;
    logic [LANE_W-1:0]     lane_q, lane_d;
    logic [WORD_W-1:0]     word_q, word_d;
    logic [CNT_W-1:0]      cap_q, cap_d;
    logic [BIN_ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic                  sat_d;

    logic                  tmr_load, tmr_expired;
    logic [TMR_W-1:0]      tmr_val;

    logic [PIX_W-1:0]      pix;
    logic [BIN_ADDR_W-1:0] bin_d;
    logic                  in_re_d, scr_re_d, scr_we_d;
    logic [IN_ADDR_W-1:0]  in_addr_d;
    logic [BIN_ADDR_W-1:0] scr_addr_d;
    logic [CNT_W-1:0]      scr_wdata_d;

    assign tmr_load = (state_q == RD_IN) || (state_q == RD_BIN);
    assign tmr_val  = (state_q == RD_IN) ? TMR_W'(IN_RD_LAT - 1) : TMR_W'(SCR_RD_LAT - 1);

    hist_lat_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    always_comb begin
        state_d     = state_q;
        clear_d     = clear_q;
        num_words_d = num_words_q;
        word_idx_d  = word_idx_q;
        lane_d      = lane_q;
        word_d      = word_q;
        cap_d       = cap_q;
        clr_idx_d   = clr_idx_q;
        sat_d       = sat_flag;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    clear_d     = cfg_clear;
                    num_words_d = cfg_num_words;
                    word_idx_d  = '0;
                    lane_d      = '0;
                    clr_idx_d   = '0;
                    sat_d       = 1'b0;
                    if (cfg_clear)                state_d = CLEAR;
                    else if (cfg_num_words == '0) state_d = FINISH;
                    else                          state_d = RD_IN;
                end
            end
            CLEAR: begin
                if (clr_idx_q == '1) begin
                    state_d = (num_words_q == '0) ? FINISH : RD_IN;
                end else begin
                    clr_idx_d = clr_idx_q + BIN_ADDR_W'(1);
                end
            end
            RD_IN: state_d = WAIT_IN;
            WAIT_IN: begin
                if (tmr_expired) begin
                    word_d  = in_mem_rdata;
                    lane_d  = '0;
                    state_d = RD_BIN;
                end
            end
            RD_BIN: state_d = WAIT_BIN;
            WAIT_BIN: begin
                if (tmr_expired) begin
                    cap_d   = scr_rdata;
                    state_d = WR_BIN;
                    if (scr_rdata == CNT_MAX) sat_d = 1'b1;
                end
            end
            WR_BIN: begin
                if (lane_q != LAST_LANE) begin
                    lane_d  = lane_q + LANE_W'(1);
                    state_d = RD_BIN;
                end else begin
                    // word_idx is one bit wider than the address so a full
                    // 2^IN_ADDR_W run terminates before the address wraps.
                    word_idx_d = word_idx_q + (IN_ADDR_W + 1)'(1);
                    state_d    = (word_idx_d == num_words_q) ? FINISH : RD_IN;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (abort) state_d = IDLE;
    end

    // Outputs are registered from next-state values so they line up with the state.
    always_comb begin
        pix         = word_d[int'(lane_d)*PIX_W +: PIX_W];
        bin_d       = BIN_ADDR_W'(bin_of(32'(pix), PIX_W - BIN_ADDR_W));
        in_re_d     = (state_d == RD_IN);
        in_addr_d   = in_re_d ? word_idx_d[IN_ADDR_W-1:0] : '0;
        scr_re_d    = (state_d == RD_BIN);
        scr_we_d    = (state_d == CLEAR) || (state_d == WR_BIN);
        scr_addr_d  = '0;
        scr_wdata_d = '0;
        if (state_d == CLEAR) begin
            scr_addr_d = clr_idx_d;
        end else if ((state_d == RD_BIN) || (state_d == WR_BIN)) begin
            scr_addr_d = bin_d;
        end
        if (state_d == WR_BIN) begin
            scr_wdata_d = (cap_d == CNT_MAX) ? CNT_MAX : cap_d + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            clear_q     <= 1'b0;
            num_words_q <= '0;
            word_idx_q  <= '0;
            lane_q      <= '0;
            word_q      <= '0;
            cap_q       <= '0;
            clr_idx_q   <= '0;
            in_mem_re   <= 1'b0;
            in_mem_addr <= '0;
            scr_re      <= 1'b0;
            scr_we      <= 1'b0;
            scr_addr    <= '0;
            scr_wdata   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            sat_flag    <= 1'b0;
        end else begin
            state_q     <= state_d;
            clear_q     <= clear_d;
            num_words_q <= num_words_d;
            word_idx_q  <= word_idx_d;
            lane_q      <= lane_d;
            word_q      <= word_d;
            cap_q       <= cap_d;
            clr_idx_q   <= clr_idx_d;
            in_mem_re   <= in_re_d;
            in_mem_addr <= in_addr_d;
            scr_re      <= scr_re_d;
            scr_we      <= scr_we_d;
            scr_addr    <= scr_addr_d;
            scr_wdata   <= scr_wdata_d;
            busy        <= (state_d != IDLE);
            done        <= (state_d == FINISH);
            sat_flag    <= sat_d;
        end
    end

endmodule
